// File: rtl/reg_bus_arbiter.sv
// Two-port arbiter for the asynchronous register bank bus.
// Port A (VME) and port B (fiber link) share one bank. Ties alternate between the ports.
// Every bus-facing output comes straight from a flop, so the external strobes and the
// tristate enable never glitch.
// A transaction runs IDLE -> SETUP -> STROBE (1 cycle for writes, READ_WAIT cycles for
// reads) -> DONE.
module reg_bus_arbiter #(
  parameter int unsigned READ_WAIT = 2,  // read strobe length in cycles, 1..15
  parameter int unsigned ADDR_W    = 18
) (
  input  logic              CLK,
  input  logic              RSTb,
  // Port A (VME)
  input  logic              A_REQ,
  input  logic              A_WR,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [31:0]       A_WDATA,
  output logic              A_ACK,
  output logic [31:0]       A_RDATA,
  // Port B (fiber link)
  input  logic              B_REQ,
  input  logic              B_WR,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [31:0]       B_WDATA,
  output logic              B_ACK,
  output logic [31:0]       B_RDATA,
  // Register bank bus
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [31:0]       BUS_WDATA,
  output logic              BUS_DATA_OE,
  input  logic [31:0]       BUS_RDATA,
  output logic              BUS_CEb,
  output logic              BUS_WEb,
  output logic              BUS_OEb,
  output logic [1:0]        GRANT
);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StDone
  } state_e;

  localparam logic [3:0] RdWait = 4'(READ_WAIT);

  state_e state_q, state_d;

  // Transaction context, latched on grant
  logic              owner_q, owner_d;  // 0 = port A, 1 = port B
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;      // read strobe cycle count, 1-based

  // Round-robin pointer: 1 = port B was granted last
  logic              last_b_q, last_b_d;

  // Registered bus and requester outputs
  logic              ceb_q, ceb_d;
  logic              web_q, web_d;
  logic              oeb_q, oeb_d;
  logic              doe_q, doe_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [1:0]        grant_q, grant_d;
  logic [31:0]       a_rdata_q, a_rdata_d;
  logic [31:0]       b_rdata_q, b_rdata_d;

  // Grant selection in IDLE: B wins if it is alone, or on a tie when A was served last
  logic              pick_b;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Winner of the current IDLE arbitration and its request fields
  always_comb begin
    pick_b    = B_REQ & (~A_REQ | ~last_b_q);
    sel_wr    = pick_b ? B_WR    : A_WR;
    sel_addr  = pick_b ? B_ADDR  : A_ADDR;
    sel_wdata = pick_b ? B_WDATA : A_WDATA;
  end

  // Next state and next values of all registered outputs
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    ceb_d     = 1'b1;
    web_d     = 1'b1;
    oeb_d     = 1'b1;
    doe_d     = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    grant_d   = grant_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    unique case (state_q)
      StIdle: begin
        grant_d = 2'b00;
        if (A_REQ || B_REQ) begin
          state_d  = StSetup;
          owner_d  = pick_b;
          last_b_d = pick_b;
          wr_d     = sel_wr;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          grant_d  = pick_b ? 2'b10 : 2'b01;
          // Drive write data one cycle ahead of the strobe
          doe_d    = sel_wr;
        end
      end

      StSetup: begin
        state_d = StStrobe;
        cnt_d   = 4'd1;
        ceb_d   = 1'b0;
        web_d   = ~wr_q;
        oeb_d   = wr_q;
        doe_d   = wr_q;
      end

      StStrobe: begin
        if (wr_q || (cnt_q == RdWait)) begin
          // Leaving the strobe: release everything and signal the owner
          state_d = StDone;
          a_ack_d = ~owner_q;
          b_ack_d = owner_q;
          if (!wr_q) begin
            if (owner_q) b_rdata_d = BUS_RDATA;
            else         a_rdata_d = BUS_RDATA;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          ceb_d = 1'b0;
          oeb_d = 1'b0;
        end
      end

      StDone: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end

      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  // FSM state register; reset aborts any transaction in flight
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Transaction context and round-robin pointer
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 4'd0;
      last_b_q <= 1'b1;  // A wins the first tie
    end else begin
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  // Registered bus strobes, acknowledges and read data
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ceb_q     <= 1'b1;
      web_q     <= 1'b1;
      oeb_q     <= 1'b1;
      doe_q     <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      grant_q   <= 2'b00;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      ceb_q     <= ceb_d;
      web_q     <= web_d;
      oeb_q     <= oeb_d;
      doe_q     <= doe_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      grant_q   <= grant_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign BUS_ADDR    = addr_q;
  assign BUS_WDATA   = wdata_q;
  assign BUS_DATA_OE = doe_q;
  assign BUS_CEb     = ceb_q;
  assign BUS_WEb     = web_q;
  assign BUS_OEb     = oeb_q;
  assign GRANT       = grant_q;
  assign A_ACK       = a_ack_q;
  assign A_RDATA     = a_rdata_q;
  assign B_ACK       = b_ack_q;
  assign B_RDATA     = b_rdata_q;

  // Bus contention and strobe-ordering invariants
  a_no_drive_fight : assert property (@(posedge CLK) disable iff (!RSTb) !(doe_q && !oeb_q));
  a_we_inside_ce   : assert property (@(posedge CLK) disable iff (!RSTb) !(!web_q && ceb_q));
  a_grant_onehot0  : assert property (@(posedge CLK) disable iff (!RSTb) $onehot0(grant_q));

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: bank model, per-transaction observation and a
// second instance built with READ_WAIT=5.
module tb_reg_bus_arbiter;

  localparam int unsigned AW = 18;

  logic          CLK  = 1'b0;
  logic          RSTb = 1'b1;

  logic          A_REQ, A_WR, B_REQ, B_WR;
  logic [AW-1:0] A_ADDR, B_ADDR;
  logic [31:0]   A_WDATA, B_WDATA;
  logic          A_ACK, B_ACK;
  logic [31:0]   A_RDATA, B_RDATA;
  logic [AW-1:0] BUS_ADDR;
  logic [31:0]   BUS_WDATA, BUS_RDATA;
  logic          BUS_DATA_OE, BUS_CEb, BUS_WEb, BUS_OEb;
  logic [1:0]    GRANT;

  // Second instance with a longer read strobe
  logic          r_a_req, r_a_wr, r_b_req, r_b_wr;
  logic [AW-1:0] r_a_addr, r_b_addr, r_bus_addr;
  logic [31:0]   r_a_wdata, r_b_wdata, r_a_rdata, r_b_rdata;
  logic          r_a_ack, r_b_ack;
  logic [31:0]   r_bus_wdata, r_bus_rdata;
  logic          r_doe, r_ceb, r_web, r_oeb;
  logic [1:0]    r_grant;

  always #5 CLK = ~CLK;

  reg_bus_arbiter #(.READ_WAIT(2), .ADDR_W(AW)) u_dut (
    .CLK(CLK), .RSTb(RSTb),
    .A_REQ(A_REQ), .A_WR(A_WR), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_ACK(A_ACK), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WR(B_WR), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_ACK(B_ACK), .B_RDATA(B_RDATA),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_DATA_OE(BUS_DATA_OE),
    .BUS_RDATA(BUS_RDATA), .BUS_CEb(BUS_CEb), .BUS_WEb(BUS_WEb), .BUS_OEb(BUS_OEb),
    .GRANT(GRANT)
  );

  reg_bus_arbiter #(.READ_WAIT(5), .ADDR_W(AW)) u_dut5 (
    .CLK(CLK), .RSTb(RSTb),
    .A_REQ(r_a_req), .A_WR(r_a_wr), .A_ADDR(r_a_addr), .A_WDATA(r_a_wdata),
    .A_ACK(r_a_ack), .A_RDATA(r_a_rdata),
    .B_REQ(r_b_req), .B_WR(r_b_wr), .B_ADDR(r_b_addr), .B_WDATA(r_b_wdata),
    .B_ACK(r_b_ack), .B_RDATA(r_b_rdata),
    .BUS_ADDR(r_bus_addr), .BUS_WDATA(r_bus_wdata), .BUS_DATA_OE(r_doe),
    .BUS_RDATA(r_bus_rdata), .BUS_CEb(r_ceb), .BUS_WEb(r_web), .BUS_OEb(r_oeb),
    .GRANT(r_grant)
  );

  // Bank model: preloaded on the first clock, written on CEb=WEb=0 edges
  logic [31:0] mem [0:255];
  bit          bank_init = 1'b0;

  always @(posedge CLK) begin
    if (!bank_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'hDEADBEEF;
      mem[8]    <= 32'hCAFEF00D;
      bank_init <= 1'b1;
    end else if (!BUS_CEb && !BUS_WEb) begin
      mem[BUS_ADDR[7:0]] <= BUS_WDATA;
    end
  end

  assign BUS_RDATA   = (!BUS_CEb && !BUS_OEb) ? mem[BUS_ADDR[7:0]] : 32'h0;
  assign r_bus_rdata = (!r_ceb && !r_oeb) ? (32'h5A5A0000 | 32'(r_bus_addr)) : 32'h0;

  // Strobe-overlap violations seen on either instance
  int viol = 0;
  always @(negedge CLK) begin
    viol <= viol + int'(BUS_DATA_OE && !BUS_OEb) + int'(!BUS_WEb && BUS_CEb)
                 + int'(r_doe && !r_oeb) + int'(!r_web && r_ceb);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input bit pb, input bit wr, input logic [AW-1:0] addr,
                       input logic [31:0] wd);
    if (pb) begin B_WR = wr; B_ADDR = addr; B_WDATA = wd; B_REQ = 1'b1; end
    else    begin A_WR = wr; A_ADDR = addr; A_WDATA = wd; A_REQ = 1'b1; end
  endtask

  // Called #1 after an edge with REQ already high; the next edge is the sampling edge.
  // Cycle n is the n-th cycle after that edge; REQ is dropped on the edge after ACK.
  task automatic observe(input bit pb, output int lat, output int n_ce, output int n_we,
                         output int n_oe, output int n_oth, output logic [31:0] st_wdata,
                         output logic [1:0] setup_gnt, output logic [AW-1:0] setup_addr,
                         output logic ack_after);
    lat = 0; n_ce = 0; n_we = 0; n_oe = 0; n_oth = 0;
    st_wdata = 32'h0; setup_gnt = 2'b00; setup_addr = '0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge CLK); #1;
      if (n == 1) begin setup_gnt = GRANT; setup_addr = BUS_ADDR; end
      if (!BUS_CEb) n_ce++;
      if (!BUS_WEb) begin n_we++; st_wdata = BUS_WDATA; end
      if (!BUS_OEb) n_oe++;
      if (pb ? A_ACK : B_ACK) n_oth++;
      if (pb ? B_ACK : A_ACK) begin lat = n; break; end
    end
    @(posedge CLK); #1;
    if (pb) B_REQ = 1'b0; else A_REQ = 1'b0;
    ack_after = pb ? B_ACK : A_ACK;
  endtask

  int          lat, n_ce, n_we, n_oe, n_oth;
  logic [31:0] st_wd;
  logic [1:0]  s_gnt;
  logic [AW-1:0] s_addr;
  logic        ack_aft;

  initial begin
    int          we_at[$];
    int          ack_at[$];
    logic [1:0]  gq[$];
    logic [1:0]  prev;
    int          bad, a_acks, b_acks, both_ack, acks;

    {A_REQ, A_WR, B_REQ, B_WR} = 4'b0;
    A_ADDR = '0; B_ADDR = '0; A_WDATA = '0; B_WDATA = '0;
    {r_a_req, r_a_wr, r_b_req, r_b_wr} = 4'b0;
    r_a_addr = '0; r_b_addr = '0; r_a_wdata = '0; r_b_wdata = '0;

    // Reset values
    #1 RSTb = 1'b0;
    #1;
    check("rst_ceb", 32'(BUS_CEb), 32'd1);
    check("rst_web", 32'(BUS_WEb), 32'd1);
    check("rst_oeb", 32'(BUS_OEb), 32'd1);
    check("rst_doe", 32'(BUS_DATA_OE), 32'd0);
    check("rst_grant", 32'(GRANT), 32'd0);
    check("rst_acks", {30'd0, A_ACK, B_ACK}, 32'd0);
    check("rst_addr", 32'(BUS_ADDR), 32'd0);
    check("rst_wdata", BUS_WDATA, 32'd0);
    check("rst_rdata", A_RDATA | B_RDATA, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RSTb = 1'b1;
    @(posedge CLK); #1;

    // Port A write
    drive(0, 1, 18'h00010, 32'h12345678);
    observe(0, lat, n_ce, n_we, n_oe, n_oth, st_wd, s_gnt, s_addr, ack_aft);
    check("wr_latency", lat, 32'd3);
    check("wr_we_cycles", n_we, 32'd1);
    check("wr_ce_cycles", n_ce, 32'd1);
    check("wr_oe_cycles", n_oe, 32'd0);
    check("wr_bus_wdata", st_wd, 32'h12345678);
    check("wr_grant", 32'(s_gnt), 32'h1);
    check("wr_bus_addr", 32'(s_addr), 32'h10);
    check("wr_other_ack", n_oth, 32'd0);
    check("wr_ack_pulse", 32'(ack_aft), 32'd0);
    check("wr_bank", mem[16], 32'h12345678);

    // Port A read, then port B read must leave A_RDATA alone
    drive(0, 0, 18'h00008, 32'h0);
    observe(0, lat, n_ce, n_we, n_oe, n_oth, st_wd, s_gnt, s_addr, ack_aft);
    check("ard_latency", lat, 32'd4);
    check("ard_data", A_RDATA, 32'hCAFEF00D);

    drive(1, 0, 18'h00004, 32'h0);
    observe(1, lat, n_ce, n_we, n_oe, n_oth, st_wd, s_gnt, s_addr, ack_aft);
    check("brd_latency", lat, 32'd4);
    check("brd_oe_cycles", n_oe, 32'd2);
    check("brd_ce_cycles", n_ce, 32'd2);
    check("brd_we_cycles", n_we, 32'd0);
    check("brd_grant", 32'(s_gnt), 32'h2);
    check("brd_other_ack", n_oth, 32'd0);
    check("brd_data", B_RDATA, 32'hDEADBEEF);
    check("brd_a_rdata_held", A_RDATA, 32'hCAFEF00D);

    drive(1, 0, 18'h00010, 32'h0);
    observe(1, lat, n_ce, n_we, n_oe, n_oth, st_wd, s_gnt, s_addr, ack_aft);
    check("brd_readback", B_RDATA, 32'h12345678);

    // Port B alone, two back-to-back writes with REQ held
    drive(1, 1, 18'h00020, 32'h11111111);
    bad = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge CLK); #1;
      if (!BUS_WEb) we_at.push_back(n);
      if (GRANT == 2'b01 || A_ACK) bad++;
      if (B_ACK) begin
        ack_at.push_back(n);
        if (ack_at.size() == 1) begin B_ADDR = 18'h00021; B_WDATA = 32'h22222222; end
        else break;
      end
    end
    @(posedge CLK); #1;
    B_REQ = 1'b0;
    check("b2b_we_pulses", we_at.size(), 32'd2);
    check("b2b_we0", (we_at.size() > 0) ? we_at[0] : -1, 32'd2);
    check("b2b_we1", (we_at.size() > 1) ? we_at[1] : -1, 32'd6);
    check("b2b_ack0", (ack_at.size() > 0) ? ack_at[0] : -1, 32'd3);
    check("b2b_ack1", (ack_at.size() > 1) ? ack_at[1] : -1, 32'd7);
    check("b2b_only_b", bad, 32'd0);
    check("b2b_bank0", mem[32], 32'h11111111);
    check("b2b_bank1", mem[33], 32'h22222222);

    // Both ports requesting continuously right after reset
    @(posedge CLK); #1 RSTb = 1'b0;
    @(posedge CLK); #1 RSTb = 1'b1;
    drive(0, 0, 18'h00004, 32'h0);
    drive(1, 0, 18'h00008, 32'h0);
    prev = 2'b00; a_acks = 0; b_acks = 0; both_ack = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (GRANT != 2'b00 && prev == 2'b00) gq.push_back(GRANT);
      prev = GRANT;
      if (A_ACK) a_acks++;
      if (B_ACK) b_acks++;
      if (A_ACK && B_ACK) both_ack++;
      if (a_acks + b_acks == 4) break;
    end
    @(posedge CLK); #1;
    A_REQ = 1'b0; B_REQ = 1'b0;
    check("rr_grants", gq.size(), 32'd4);
    check("rr_g0", 32'((gq.size() > 0) ? gq[0] : 2'b00), 32'h1);
    check("rr_g1", 32'((gq.size() > 1) ? gq[1] : 2'b00), 32'h2);
    check("rr_g2", 32'((gq.size() > 2) ? gq[2] : 2'b00), 32'h1);
    check("rr_g3", 32'((gq.size() > 3) ? gq[3] : 2'b00), 32'h2);
    check("rr_a_acks", a_acks, 32'd2);
    check("rr_b_acks", b_acks, 32'd2);
    check("rr_both_ack", both_ack, 32'd0);
    check("rr_a_data", A_RDATA, 32'hDEADBEEF);
    check("rr_b_data", B_RDATA, 32'hCAFEF00D);

    // Reset during a read strobe aborts, then the held request restarts
    drive(0, 0, 18'h00008, 32'h0);
    @(posedge CLK);
    @(posedge CLK); #1;
    check("abort_in_strobe", 32'(BUS_OEb), 32'd0);
    RSTb = 1'b0;
    #1;
    check("abort_ceb", 32'(BUS_CEb), 32'd1);
    check("abort_oeb", 32'(BUS_OEb), 32'd1);
    check("abort_doe", 32'(BUS_DATA_OE), 32'd0);
    check("abort_ack", 32'(A_ACK), 32'd0);
    check("abort_grant", 32'(GRANT), 32'd0);
    check("abort_rdata", A_RDATA, 32'd0);
    @(posedge CLK); #1 RSTb = 1'b1;
    observe(0, lat, n_ce, n_we, n_oe, n_oth, st_wd, s_gnt, s_addr, ack_aft);
    check("restart_latency", lat, 32'd4);
    check("restart_data", A_RDATA, 32'hCAFEF00D);

    // READ_WAIT=5 instance
    r_b_addr = 18'h00003; r_b_wr = 1'b0; r_b_req = 1'b1;
    lat = 0; n_oe = 0; acks = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      if (!r_oeb) n_oe++;
      if (r_a_ack) acks++;
      if (r_b_ack) begin lat = n; break; end
    end
    @(posedge CLK); #1;
    r_b_req = 1'b0;
    check("rw5_latency", lat, 32'd7);
    check("rw5_oe_cycles", n_oe, 32'd5);
    check("rw5_data", r_b_rdata, 32'h5A5A0003);
    check("rw5_other_ack", acks, 32'd0);

    @(posedge CLK); #1;
    check("strobe_overlap", viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
